// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the rv32i datapath and a word-addressed data ram.
// Handles byte-addressed RV32I loads/stores; sub-word stores use read-modify-write.
module lsu_mem_ctrl #(
    parameter int MEM_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // resp_valid is a single-cycle pulse with no back-pressure.
    typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, RESP} state_t;

    state_t      state, state_next;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;

    logic        funct3_legal;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic        in_access;

    always_comb begin
        funct3_legal = req_we ? (req_funct3 inside {3'd0, 3'd1, 3'd2})
                              : (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
        req_err      = !funct3_legal || misaligned || out_of_range;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_next = RESP;
                    else if (req_we && (req_funct3 != 3'd2))
                        state_next = RMW_RD;
                    else
                        state_next = ACCESS;
                end
            end
            ACCESS:  state_next = RESP;
            RMW_RD:  state_next = RMW_WR;
            RMW_WR:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane selection is little-endian: byte k lives in bits 8k+7:8k.
    always_comb begin
        load_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        load_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'd0:    load_data = {{24{load_byte[7]}}, load_byte};
            3'd1:    load_data = {{16{load_half[15]}}, load_half};
            3'd4:    load_data = {24'h000000, load_byte};
            3'd5:    load_data = {16'h0000, load_half};
            default: load_data = mem_rdata;
        endcase
        merged = merge_q;
        if (funct3_q[1:0] == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // Strobes are gated by rst_n so no ram write lands on an edge held in reset.
    always_comb begin
        in_access  = (state == ACCESS) || (state == RMW_RD) || (state == RMW_WR);
        req_ready  = (state == IDLE);
        resp_valid = rst_n && (state == RESP);
        mem_read   = rst_n && ((state == RMW_RD) || ((state == ACCESS) && !we_q));
        mem_write  = rst_n && ((state == RMW_WR) || ((state == ACCESS) && we_q));
        mem_addr   = in_access ? {2'b00, addr_q[31:2]} : 32'h0;
        mem_wdata  = 32'h0;
        if ((state == ACCESS) && we_q)
            mem_wdata = wdata_q;
        else if (state == RMW_WR)
            mem_wdata = merged;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            merge_q    <= 32'h0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        if (req_err) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end
                    end
                end
                ACCESS: begin
                    resp_err   <= 1'b0;
                    resp_rdata <= we_q ? 32'h0 : load_data;
                end
                RMW_RD: merge_q <= mem_rdata;
                RMW_WR: begin
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                end
                default: ;
            endcase
        end
    end

endmodule
